mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for an asynchronous byte-wide SRAM-style memory.
// Each access walks IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> HOLD, with every output registered.
module mem_arbiter #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p0_wdata,
  input  logic [7:0]  p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [7:0]  p0_rdata,
  output logic [7:0]  p1_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_o,
  input  logic [7:0]  mem_data_i,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        sel;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    sel          = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie the port that did not win last time goes first.
          sel     = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          grant_d = sel;
          we_d    = sel ? p1_we : p0_we;
          addr_d  = sel ? p1_addr : p0_addr;
          wdata_d = sel ? p1_wdata : p0_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        oe_n_d  = we_q;
        we_n_d  = ~we_q;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = HOLD;
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_data_i;
            else         rdata0_d = mem_data_i;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          oe_n_d = we_q;
          we_n_d = ~we_q;
        end
      end
      HOLD: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign p0_ack     = ack0_q;
  assign p1_ack     = ack1_q;
  assign p0_rdata   = rdata0_q;
  assign p1_rdata   = rdata1_q;
  assign mem_addr   = addr_q;
  assign mem_data_o = wdata_q;
  assign mem_oe_n   = oe_n_q;
  assign mem_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at STROBE_CYCLES=1 and one at 3, each with a behavioural memory.
module tb_mem_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset = 1'b1;
  logic        p0_req = 0, p1_req = 0, p0_we = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p1_addr = 0;
  logic [7:0]  p0_wdata = 0, p1_wdata = 0;
  logic        p0_ack, p1_ack, mem_oe_n, mem_we_n;
  logic [7:0]  p0_rdata, p1_rdata, mem_data_o;
  logic [7:0]  mem_data_i = 8'h00;
  logic [15:0] mem_addr;

  logic        q_req = 0;
  logic [15:0] q_addr = 0;
  logic        q_ack, q_ack1, q_oe_n, q_we_n;
  logic [7:0]  q_rdata, q_rdata1, q_data_o;
  logic [7:0]  q_data_i = 8'h00;
  logic [15:0] q_mem_addr;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total = 0;

  logic [7:0] mem [0:65535];
  int oe_low_cnt = 0, we_low_cnt = 0, overlap_cnt = 0, p0_ack_cnt = 0, p1_ack_cnt = 0, oe3_low_cnt = 0;
  logic [15:0] wr_addr_seen = 0;
  logic [7:0]  wr_data_seen = 0;

  always #5 cpu_clk = ~cpu_clk;

  mem_arbiter #(.STROBE_CYCLES(1)) u_dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  mem_arbiter #(.STROBE_CYCLES(3)) u_dut3 (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .p0_req(q_req), .p1_req(1'b0), .p0_we(1'b0), .p1_we(1'b0),
    .p0_addr(q_addr), .p1_addr(16'h0000), .p0_wdata(8'h00), .p1_wdata(8'h00),
    .p0_ack(q_ack), .p1_ack(q_ack1), .p0_rdata(q_rdata), .p1_rdata(q_rdata1),
    .mem_addr(q_mem_addr), .mem_data_o(q_data_o), .mem_data_i(q_data_i),
    .mem_oe_n(q_oe_n), .mem_we_n(q_we_n)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory latches read data on the falling edge of oe_n and commits writes on the rising edge of we_n.
  always @(negedge mem_oe_n) mem_data_i <= mem[mem_addr];
  always @(posedge mem_we_n) if (cpu_reset) mem[mem_addr] = mem_data_o;
  always @(negedge q_oe_n) q_data_i <= pat(q_mem_addr);

  always @(negedge cpu_clk) begin
    if (!mem_oe_n) oe_low_cnt++;
    if (!mem_we_n) begin
      we_low_cnt++;
      wr_addr_seen = mem_addr;
      wr_data_seen = mem_data_o;
    end
    if (!mem_oe_n && !mem_we_n) overlap_cnt++;
    if (p0_ack && p1_ack) overlap_cnt++;
    if (p0_ack) p0_ack_cnt++;
    if (p1_ack) p1_ack_cnt++;
    if (!q_oe_n) oe3_low_cnt++;
  end

  task automatic tick();
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(p0_ack || p1_ack) && n < 20);
  endtask

  task automatic test_reset();
    cpu_reset = 1'b0;
    tick(); tick();
    total++; if ({mem_oe_n, mem_we_n, p0_ack, p1_ack} !== 4'b1100)
      $display("FAIL reset_ctl: got %b expected 1100", {mem_oe_n, mem_we_n, p0_ack, p1_ack}); else passed++;
    total++; if ({mem_addr, mem_data_o} !== 24'h000000)
      $display("FAIL reset_bus: got %h expected 000000", {mem_addr, mem_data_o}); else passed++;
    total++; if ({p0_rdata, p1_rdata} !== 16'h0000)
      $display("FAIL reset_rdata: got %h expected 0000", {p0_rdata, p1_rdata}); else passed++;
    total++; if (q_oe_n !== 1'b1)
      $display("FAIL reset_oe3: got %b expected 1", q_oe_n); else passed++;
    cpu_reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int n, oe0, we0;
    exp_t e;
    mem[16'h1000] = 8'h86;
    oe0 = oe_low_cnt; we0 = we_low_cnt;
    p0_req = 1; p0_we = 0; p0_addr = 16'h1000;
    sb.push_back('{port: 1'b0, we: 1'b0, addr: 16'h1000, data: 8'h86});
    wait_ack(n);
    p0_req = 0;
    total++; if (n !== 3) $display("FAIL read_latency: got %0d expected 3", n); else passed++;
    e = sb.pop_front();
    total++; if ({p1_ack, p0_ack} !== {e.port, ~e.port})
      $display("FAIL read_port: got %b expected %b", {p1_ack, p0_ack}, {e.port, ~e.port}); else passed++;
    total++; if (p0_rdata !== e.data) $display("FAIL read_data: got %h expected %h", p0_rdata, e.data); else passed++;
    total++; if (oe_low_cnt - oe0 !== 1 || we_low_cnt - we0 !== 0)
      $display("FAIL read_strobes: got oe=%0d we=%0d expected oe=1 we=0", oe_low_cnt - oe0, we_low_cnt - we0); else passed++;
    $display("read p0 addr=%h rdata=%h latency=%0d", e.addr, p0_rdata, n);
    tick();
  endtask

  task automatic test_single_write();
    int n, we0, a0, a1;
    exp_t e;
    we0 = we_low_cnt; a0 = p0_ack_cnt; a1 = p1_ack_cnt;
    p1_req = 1; p1_we = 1; p1_addr = 16'h0001; p1_wdata = 8'h5C;
    sb.push_back('{port: 1'b1, we: 1'b1, addr: 16'h0001, data: 8'h5C});
    wait_ack(n);
    p1_req = 0; p1_we = 0;
    e = sb.pop_front();
    total++; if (n !== 3 || p1_ack !== 1'b1) $display("FAIL write_ack: got n=%0d p1_ack=%b expected n=3 p1_ack=1", n, p1_ack); else passed++;
    total++; if (we_low_cnt - we0 !== 1) $display("FAIL write_we_cycles: got %0d expected 1", we_low_cnt - we0); else passed++;
    total++; if ({wr_addr_seen, wr_data_seen} !== {e.addr, e.data})
      $display("FAIL write_bus: got %h expected %h", {wr_addr_seen, wr_data_seen}, {e.addr, e.data}); else passed++;
    total++; if (mem[e.addr] !== e.data) $display("FAIL write_mem: got %h expected %h", mem[e.addr], e.data); else passed++;
    tick(); tick();
    total++; if (p1_ack_cnt - a1 !== 1 || p0_ack_cnt - a0 !== 0)
      $display("FAIL write_ack_count: got p1=%0d p0=%0d expected p1=1 p0=0", p1_ack_cnt - a1, p0_ack_cnt - a0); else passed++;
    $display("write p1 addr=%h data=%h latency=%0d", e.addr, e.data, n);
  endtask

  task automatic test_tie();
    int n, ov0;
    exp_t e;
    cpu_reset = 1'b0; tick(); cpu_reset = 1'b1; tick();
    mem[16'h2000] = 8'h11;
    mem[16'h3000] = 8'h22;
    ov0 = overlap_cnt;
    p0_req = 1; p0_we = 0; p0_addr = 16'h2000;
    p1_req = 1; p1_we = 0; p1_addr = 16'h3000;
    for (int k = 0; k < 4; k++)
      sb.push_back('{port: k[0], we: 1'b0, addr: k[0] ? 16'h3000 : 16'h2000, data: k[0] ? 8'h22 : 8'h11});
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      if (k == 3) begin p0_req = 0; p1_req = 0; end
      e = sb.pop_front();
      total++; if (n !== (k == 0 ? 3 : 4)) $display("FAIL tie_gap%0d: got %0d expected %0d", k, n, k == 0 ? 3 : 4); else passed++;
      total++; if ({p1_ack, p0_ack} !== {e.port, ~e.port})
        $display("FAIL tie_order%0d: got %b expected %b", k, {p1_ack, p0_ack}, {e.port, ~e.port}); else passed++;
      total++; if ((e.port ? p1_rdata : p0_rdata) !== e.data)
        $display("FAIL tie_data%0d: got %h expected %h", k, e.port ? p1_rdata : p0_rdata, e.data); else passed++;
      $display("tie ack%0d port=%0d rdata=%h gap=%0d", k, e.port, e.port ? p1_rdata : p0_rdata, n);
    end
    tick();
    total++; if (overlap_cnt !== ov0) $display("FAIL tie_overlap: got %0d expected 0", overlap_cnt - ov0); else passed++;
  endtask

  task automatic test_stretch();
    int n, oe0;
    exp_t e;
    oe0 = oe3_low_cnt;
    q_req = 1; q_addr = 16'h1234;
    sb.push_back('{port: 1'b0, we: 1'b0, addr: 16'h1234, data: pat(16'h1234)});
    n = 0;
    do begin tick(); n++; end while (!q_ack && n < 20);
    q_req = 0;
    e = sb.pop_front();
    total++; if (n !== 5) $display("FAIL stretch_latency: got %0d expected 5", n); else passed++;
    total++; if (oe3_low_cnt - oe0 !== 3) $display("FAIL stretch_oe_cycles: got %0d expected 3", oe3_low_cnt - oe0); else passed++;
    total++; if (q_rdata !== e.data) $display("FAIL stretch_data: got %h expected %h", q_rdata, e.data); else passed++;
    $display("stretch p0 addr=%h rdata=%h latency=%0d", e.addr, q_rdata, n);
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n, a0, a1, we0;
    exp_t e;
    a0 = p0_ack_cnt; a1 = p1_ack_cnt;
    p0_req = 1; p0_we = 1; p0_addr = 16'h0000; p0_wdata = 8'h77;
    tick(); tick();
    total++; if (mem_we_n !== 1'b0) $display("FAIL rst_pre_strobe: got %b expected 0", mem_we_n); else passed++;
    cpu_reset = 1'b0;
    #1;
    total++; if ({mem_we_n, mem_oe_n, mem_data_o} !== {2'b11, 8'h00})
      $display("FAIL rst_async: got %h expected 300", {mem_we_n, mem_oe_n, mem_data_o}); else passed++;
    p0_req = 0; p0_we = 0;
    tick(); tick();
    cpu_reset = 1'b1;
    tick(); tick(); tick();
    total++; if (p0_ack_cnt - a0 !== 0 || p1_ack_cnt - a1 !== 0)
      $display("FAIL rst_no_ack: got p0=%0d p1=%0d expected 0 0", p0_ack_cnt - a0, p1_ack_cnt - a1); else passed++;
    we0 = we_low_cnt;
    p0_req = 1; p0_we = 1; p0_addr = 16'h0000; p0_wdata = 8'hA5;
    sb.push_back('{port: 1'b0, we: 1'b1, addr: 16'h0000, data: 8'hA5});
    wait_ack(n);
    p0_req = 0; p0_we = 0;
    e = sb.pop_front();
    total++; if (n !== 3 || p0_ack !== 1'b1) $display("FAIL rst_after_ack: got n=%0d p0_ack=%b expected n=3 p0_ack=1", n, p0_ack); else passed++;
    total++; if (mem[e.addr] !== e.data || we_low_cnt - we0 !== 1)
      $display("FAIL rst_after_mem: got %h/%0d expected %h/1", mem[e.addr], we_low_cnt - we0, e.data); else passed++;
    $display("reset-abort then write p0 addr=%h data=%h latency=%0d", e.addr, e.data, n);
    tick();
  endtask

  task automatic test_withdrawn();
    int n, oe0, a1;
    exp_t e;
    oe0 = oe_low_cnt; a1 = p1_ack_cnt;
    p0_req = 1; p0_we = 0; p0_addr = 16'h1000;
    p1_we = 0; p1_addr = 16'h3000;
    sb.push_back('{port: 1'b0, we: 1'b0, addr: 16'h1000, data: 8'h86});
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) p1_req = 1;
      if (n == 2) p1_req = 0;
    end while (!(p0_ack || p1_ack) && n < 20);
    p0_req = 0;
    e = sb.pop_front();
    total++; if (n !== 3 || p0_rdata !== e.data) $display("FAIL wd_p0: got n=%0d rdata=%h expected n=3 rdata=%h", n, p0_rdata, e.data); else passed++;
    for (int i = 0; i < 6; i++) tick();
    total++; if (p1_ack_cnt - a1 !== 0 || oe_low_cnt - oe0 !== 1)
      $display("FAIL wd_p1_cycle: got p1_acks=%0d oe=%0d expected 0 1", p1_ack_cnt - a1, oe_low_cnt - oe0); else passed++;
    total++; if (p1_rdata !== 8'h00) $display("FAIL wd_p1_rdata: got %h expected 00", p1_rdata); else passed++;
    $display("withdrawn p1 req: p0 rdata=%h p1 acks=%0d", p0_rdata, p1_ack_cnt - a1);
  endtask

  initial begin
    #1;
    test_reset();
    test_single_read();
    test_single_write();
    test_tie();
    test_stretch();
    test_reset_mid_write();
    test_withdrawn();
    total++; if (sb.size() !== 0) $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
